// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single word-addressed
// data memory. One transaction is in flight at a time: accept (IDLE), drive the
// memory command for one cycle (ISSUE), return a one-cycle response (RESP).
// Addresses at or above DEPTH are answered with an error and never reach memory.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   reqN_valid/ready/we/addr/wdata   request handshake and payload, N = 0 (core), 1 (DMA)
//   rspN_valid/err/rdata             registered one-cycle response to the granted port
//   MemRead, MemWrite                memory strobes, high only during ISSUE
//   address, WriteData               memory address and write data, zero outside ISSUE
//   ReadData                         memory read data, valid by the end of ISSUE
module dmem_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 512
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic            req0_we,
    input  logic [XLEN-1:0] req0_addr,
    input  logic [XLEN-1:0] req0_wdata,
    output logic            rsp0_valid,
    output logic            rsp0_err,
    output logic [XLEN-1:0] rsp0_rdata,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic            req1_we,
    input  logic [XLEN-1:0] req1_addr,
    input  logic [XLEN-1:0] req1_wdata,
    output logic            rsp1_valid,
    output logic            rsp1_err,
    output logic [XLEN-1:0] rsp1_rdata,

    output logic            MemRead,
    output logic            MemWrite,
    output logic [XLEN-1:0] address,
    output logic [XLEN-1:0] WriteData,
    input  logic [XLEN-1:0] ReadData
);

    localparam logic [XLEN-1:0] DepthW = XLEN'(DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e          state_q, state_d;
    logic            last_grant_q;
    logic            port_q;
    logic            we_q;
    logic            err_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;

    logic            any_valid;
    logic            grant;
    logic            accept;
    logic            sel_we;
    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] sel_wdata;
    logic [XLEN-1:0] rsp_data;

    // Arbitration: a lone requester always wins; on a tie the port that was
    // not granted last time wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
        req0_ready = (state_q == StIdle) && any_valid && !grant;
        req1_ready = (state_q == StIdle) && any_valid && grant;
        accept     = req0_ready | req1_ready;
        sel_we     = grant ? req1_we    : req0_we;
        sel_addr   = grant ? req1_addr  : req0_addr;
        sel_wdata  = grant ? req1_wdata : req0_wdata;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Memory command is only presented during ISSUE and only for in-range addresses.
    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        address   = '0;
        WriteData = '0;
        if (state_q == StIssue && !err_q) begin
            MemRead   = !we_q;
            MemWrite  = we_q;
            address   = addr_q;
            WriteData = wdata_q;
        end
    end

    // Only successful reads return memory data.
    assign rsp_data = (!we_q && !err_q) ? ReadData : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp0_valid   <= 1'b0;
            rsp0_err     <= 1'b0;
            rsp0_rdata   <= '0;
            rsp1_valid   <= 1'b0;
            rsp1_err     <= 1'b0;
            rsp1_rdata   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                port_q       <= grant;
                last_grant_q <= grant;
                we_q         <= sel_we;
                addr_q       <= sel_addr;
                wdata_q      <= sel_wdata;
                err_q        <= (sel_addr >= DepthW);
            end
            // Response registers are loaded at the end of ISSUE and cleared one
            // cycle later, so they are non-zero only while rsp_valid is high.
            rsp0_valid <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_valid <= 1'b0;
            rsp1_err   <= 1'b0;
            rsp1_rdata <= '0;
            if (state_q == StIssue) begin
                if (port_q) begin
                    rsp1_valid <= 1'b1;
                    rsp1_err   <= err_q;
                    rsp1_rdata <= rsp_data;
                end else begin
                    rsp0_valid <= 1'b1;
                    rsp0_err   <= err_q;
                    rsp0_rdata <= rsp_data;
                end
            end
        end
    end

endmodule
